block_requester: RTL

- Initiator side of the cache block access handshake (enable / write / data / ack).
- Accepts single read or write requests from the cache controller on a valid/ready interface.
- Drives one storage block through a full enable-assert / ack / enable-release cycle and returns read data (or write completion) on a valid/ready response channel.
- One outstanding transaction; sits between the cache controller and each block instance.

---
 rtl/block_requester_pkg.sv | 14 +
 rtl/block_requester_if.sv | 35 +++
 rtl/block_req_watchdog.sv | 31 +++
 rtl/block_requester.sv | 129 ++++++++++++
 4 files changed

// File: rtl/block_requester_pkg.sv
// Shared constants for the block requester: state encodings and
// default sizing for the data path and the ack watchdog.
package block_requester_pkg;

   localparam int DEF_DATA_WIDTH     = 16;
   localparam int DEF_TIMEOUT_CYCLES = 15;
   localparam int DEF_CNT_WIDTH      = 4;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_ACK = 2'd1;
   localparam logic [1:0] S_RELEASE  = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

endpackage

// File: rtl/block_requester_if.sv
// Request/response channel plus block enable/write/data/ack wires.
// master = the requester, slave = controller and block side.
interface block_requester_if #(
   parameter int DATA_WIDTH = 16
) ();

   logic                  req_valid;
   logic                  req_write;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  req_ready;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  resp_err;
   logic                  resp_ready;
   logic                  blk_enable;
   logic                  blk_write;
   logic [DATA_WIDTH-1:0] blk_wdata;
   logic [DATA_WIDTH-1:0] blk_rdata;
   logic                  blk_ack;

   modport master (
      input  req_valid, req_write, req_data, resp_ready,
      input  blk_rdata, blk_ack,
      output req_ready, resp_valid, resp_data, resp_err,
      output blk_enable, blk_write, blk_wdata
   );

   modport slave (
      output req_valid, req_write, req_data, resp_ready,
      output blk_rdata, blk_ack,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  blk_enable, blk_write, blk_wdata
   );

endinterface

// File: rtl/block_req_watchdog.sv
// Counts consecutive stalled edges; flags expiry on the edge that
// would reach TIMEOUT_CYCLES. Clears whenever the stall ends.
module block_req_watchdog
   import block_requester_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_expired
);

   logic [CNT_WIDTH-1:0] r_cnt;

   assign o_expired = i_inc &&
                      (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear || o_expired) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/block_requester.sv
// Initiator for the block enable/write/data/ack handshake.
// Optional ack watchdog enabled by defining BLOCK_REQ_TIMEOUT_EN.
module block_requester
   import block_requester_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   block_requester_if.master  bus
);

   if (CNT_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_cnt
      $error("CNT_WIDTH cannot hold TIMEOUT_CYCLES");
   end

   logic [1:0]            r_state;
   logic                  r_blk_enable;
   logic                  r_blk_write;
   logic [DATA_WIDTH-1:0] r_blk_wdata;
   logic                  r_resp_valid;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic                  w_timeout;

`ifdef BLOCK_REQ_TIMEOUT_EN
   logic r_resp_err;
   logic w_wd_inc;

   // Stalled: waiting for ack to rise, or for it to fall again
   assign w_wd_inc = ((r_state == S_WAIT_ACK) && !bus.blk_ack) ||
                     ((r_state == S_RELEASE) && bus.blk_ack);

   block_req_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (!w_wd_inc),
      .i_inc     (w_wd_inc),
      .o_expired (w_timeout)
   );

   assign bus.resp_err = r_resp_err;
`else
   assign w_timeout    = 1'b0;
   assign bus.resp_err = 1'b0;
`endif

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign bus.blk_enable = r_blk_enable;
   assign bus.blk_write  = r_blk_write;
   assign bus.blk_wdata  = r_blk_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_blk_enable <= 1'b0;
         r_blk_write  <= 1'b0;
         r_blk_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
`ifdef BLOCK_REQ_TIMEOUT_EN
         r_resp_err   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_blk_enable <= 1'b1;
                  r_blk_write  <= bus.req_write;
                  if (bus.req_write) begin
                     r_blk_wdata <= bus.req_data;
                  end
                  r_state <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (bus.blk_ack) begin
                  r_resp_data  <= bus.blk_rdata;
                  r_blk_enable <= 1'b0;
                  r_blk_write  <= 1'b0;
                  r_state      <= S_RELEASE;
               end else if (w_timeout) begin
                  r_blk_enable <= 1'b0;
                  r_blk_write  <= 1'b0;
                  r_resp_data  <= '0;
                  r_resp_valid <= 1'b1;
`ifdef BLOCK_REQ_TIMEOUT_EN
                  r_resp_err   <= 1'b1;
`endif
                  r_state      <= S_RESP;
               end
            end
            S_RELEASE: begin
               // Block must drop ack before the next access may start
               if (!bus.blk_ack) begin
                  r_resp_valid <= 1'b1;
`ifdef BLOCK_REQ_TIMEOUT_EN
                  r_resp_err   <= 1'b0;
`endif
                  r_state      <= S_RESP;
               end else if (w_timeout) begin
                  r_resp_data  <= '0;
                  r_resp_valid <= 1'b1;
`ifdef BLOCK_REQ_TIMEOUT_EN
                  r_resp_err   <= 1'b1;
`endif
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
